// File: rtl/multi_channel_timestamp_printer_pkg.sv
// Shared constants and types for the multi-channel timestamp printer:
// ASCII framing bytes, command bytes, the software event id and printer states.
package multi_channel_timestamp_printer_pkg;

  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] SW_EVENT_ID = 4'hF;

  localparam logic [7:0] CMD_ENABLE  = 8'h65;  // 'e'
  localparam logic [7:0] CMD_DISABLE = 8'h64;  // 'd'
  localparam logic [7:0] CMD_CLEAR   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_HOST    = 8'h68;  // 'h'

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } prn_state_t;

endpackage

// File: rtl/multi_channel_timestamp_printer_event_fifo.sv
// Synchronous event FIFO with a fall-through head; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module multi_channel_timestamp_printer_event_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/multi_channel_timestamp_printer.sv
// Timestamps input edges against a free-running counter, queues them and prints
// each event over a UART byte interface as "C<id>:<ts>,<seq>\r\n" in hex.
module multi_channel_timestamp_printer
  import multi_channel_timestamp_printer_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int COUNT_W   = 32,
  parameter int SEQ_W     = 16,
  parameter int DEPTH     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] sig_in,
  output logic [7:0]     tx_data,
  output logic           new_tx_data,
  input  logic           tx_busy,
  input  logic [7:0]     rx_data,
  input  logic           new_rx_data,
  output logic           overrun,
  output logic [7:0]     drop_count
);

  localparam int TS_DIG  = COUNT_W / 4;
  localparam int SEQ_DIG = SEQ_W / 4;
  localparam logic [7:0] TS_FIRST  = 8'd3;
  localparam logic [7:0] COMMA_IDX = 8'(3 + TS_DIG);
  localparam logic [7:0] SEQ_FIRST = 8'(4 + TS_DIG);
  localparam logic [7:0] CR_IDX    = 8'(4 + TS_DIG + SEQ_DIG);
  localparam logic [7:0] LINE_LEN  = 8'(6 + TS_DIG + SEQ_DIG);

  function automatic logic [7:0] hex_ascii(input logic [3:0] nyb);
    return (nyb < 4'd10) ? (8'h30 + {4'h0, nyb}) : (8'h37 + {4'h0, nyb});
  endfunction

  logic [COUNT_W-1:0] count_reg;
  logic               enable_reg;
  logic               overrun_reg;
  logic [7:0]         drop_count_reg;
  logic               sw_pend_reg;
  logic [COUNT_W-1:0] sw_ts_reg;

  logic [NCH-1:0]     edge_flag;
  logic [NCH-1:0]     pending_reg;
  logic [NCH-1:0]     cap_en;
  logic [NCH-1:0]     edge_drop;
  logic [NCH-1:0]     grant_oh;
  logic [COUNT_W-1:0] cap_ts [NCH];

  logic               cmd_enable, cmd_disable, cmd_clear, cmd_host;
  assign cmd_enable  = new_rx_data && (rx_data == CMD_ENABLE);
  assign cmd_disable = new_rx_data && (rx_data == CMD_DISABLE);
  assign cmd_clear   = new_rx_data && (rx_data == CMD_CLEAR);
  assign cmd_host    = new_rx_data && (rx_data == CMD_HOST);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic               sync1_reg, sync2_reg, sync3_reg;
      logic               pend_reg;
      logic [COUNT_W-1:0] cap_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          sync3_reg <= 1'b0;
        end else begin
          sync1_reg <= sig_in[gi];
          sync2_reg <= sync1_reg;
          sync3_reg <= sync2_reg;
        end
      end

      if (EDGE_MODE == 0) begin : g_rise
        assign edge_flag[gi] = sync2_reg & ~sync3_reg;
      end else if (EDGE_MODE == 1) begin : g_fall
        assign edge_flag[gi] = ~sync2_reg & sync3_reg;
      end else begin : g_both
        assign edge_flag[gi] = sync2_reg ^ sync3_reg;
      end

      // An edge while the previous capture is still waiting is lost, not merged.
      assign cap_en[gi]    = edge_flag[gi] && enable_reg && !pend_reg;
      assign edge_drop[gi] = edge_flag[gi] && enable_reg && pend_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= 1'b0;
          cap_reg  <= '0;
        end else begin
          pend_reg <= (pend_reg & ~grant_oh[gi]) | cap_en[gi];
          if (cap_en[gi]) cap_reg <= count_reg;
        end
      end

      assign pending_reg[gi] = pend_reg;
      assign cap_ts[gi]      = cap_reg;
    end
  endgenerate

  logic               any_pend;
  logic [3:0]         grant_id;
  logic [COUNT_W-1:0] grant_ts;

  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    grant_ts = '0;
    any_pend = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_id    = 4'(i);
        grant_ts    = cap_ts[i];
        any_pend    = 1'b1;
      end
    end
  end

  logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [COUNT_W+3:0]   fifo_head;
  logic                 push_req, fifo_room, fifo_drop;
  logic                 sw_grant, host_accept, host_drop;
  logic [3:0]           push_id;
  logic [COUNT_W-1:0]   push_ts;

  // Software events only get the push port when no channel is waiting.
  assign sw_grant    = sw_pend_reg && !any_pend;
  assign push_req    = any_pend || sw_pend_reg;
  assign push_id     = any_pend ? grant_id : SW_EVENT_ID;
  assign push_ts     = any_pend ? grant_ts : sw_ts_reg;
  assign fifo_room   = !fifo_full || fifo_pop;
  assign fifo_push   = push_req && fifo_room;
  assign fifo_drop   = push_req && !fifo_room;
  assign host_accept = cmd_host && (!sw_pend_reg || sw_grant);
  assign host_drop   = cmd_host && sw_pend_reg && !sw_grant;

  multi_channel_timestamp_printer_event_fifo #(
    .WIDTH (4 + COUNT_W),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({push_id, push_ts}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  logic [4:0] drop_inc;
  logic [7:0] drop_base;
  logic [8:0] drop_sum;
  logic       any_drop;

  always_comb begin
    drop_inc = {4'b0, fifo_drop} + {4'b0, host_drop};
    for (int i = 0; i < NCH; i++) begin
      drop_inc = drop_inc + {4'b0, edge_drop[i]};
    end
    drop_base = cmd_clear ? 8'd0 : drop_count_reg;
    drop_sum  = {1'b0, drop_base} + {4'b0, drop_inc};
  end

  assign any_drop = (|edge_drop) || fifo_drop || host_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      enable_reg     <= 1'b1;
      overrun_reg    <= 1'b0;
      drop_count_reg <= '0;
      sw_pend_reg    <= 1'b0;
      sw_ts_reg      <= '0;
    end else begin
      count_reg      <= count_reg + 1'b1;
      if (cmd_enable)  enable_reg <= 1'b1;
      if (cmd_disable) enable_reg <= 1'b0;
      overrun_reg    <= (overrun_reg && !cmd_clear) || any_drop;
      drop_count_reg <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      sw_pend_reg    <= (sw_pend_reg && !sw_grant) || host_accept;
      if (host_accept) sw_ts_reg <= count_reg;
    end
  end

  prn_state_t         state_reg, state_next;
  logic               send_fire;
  logic [7:0]         byte_idx_reg;
  logic [3:0]         id_reg;
  logic [COUNT_W-1:0] ts_sh_reg;
  logic [SEQ_W-1:0]   seq_reg;
  logic [SEQ_W-1:0]   seq_sh_reg;
  logic [7:0]         tx_data_reg;
  logic               new_tx_data_reg;
  logic [7:0]         cur_byte;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // The strobe is registered, so it is visible during GAP; the following SEND
  // cycle is the guaranteed idle cycle between strobes.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    send_fire  = 1'b0;
    case (state_reg)
      ST_IDLE: if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD: begin
        fifo_pop   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: if (!tx_busy) begin
        send_fire  = 1'b1;
        state_next = ST_GAP;
      end
      ST_GAP:  state_next = (byte_idx_reg == LINE_LEN) ? ST_IDLE : ST_SEND;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_byte = ASCII_LF;
    if (byte_idx_reg == 8'd0)            cur_byte = ASCII_C;
    else if (byte_idx_reg == 8'd1)       cur_byte = hex_ascii(id_reg);
    else if (byte_idx_reg == 8'd2)       cur_byte = ASCII_COLON;
    else if (byte_idx_reg < COMMA_IDX)  cur_byte = hex_ascii(ts_sh_reg[COUNT_W-1 -: 4]);
    else if (byte_idx_reg == COMMA_IDX) cur_byte = ASCII_COMMA;
    else if (byte_idx_reg < CR_IDX)     cur_byte = hex_ascii(seq_sh_reg[SEQ_W-1 -: 4]);
    else if (byte_idx_reg == CR_IDX)    cur_byte = ASCII_CR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_tx_data_reg <= 1'b0;
      tx_data_reg     <= '0;
      byte_idx_reg    <= '0;
      id_reg          <= '0;
      ts_sh_reg       <= '0;
      seq_reg         <= '0;
      seq_sh_reg      <= '0;
    end else begin
      new_tx_data_reg <= send_fire;
      if (state_reg == ST_LOAD) begin
        id_reg       <= fifo_head[COUNT_W+3:COUNT_W];
        ts_sh_reg    <= fifo_head[COUNT_W-1:0];
        seq_reg      <= seq_reg + 1'b1;
        seq_sh_reg   <= seq_reg + 1'b1;
        byte_idx_reg <= '0;
      end
      if (send_fire) begin
        tx_data_reg  <= cur_byte;
        byte_idx_reg <= byte_idx_reg + 1'b1;
        if (byte_idx_reg >= TS_FIRST && byte_idx_reg < COMMA_IDX)
          ts_sh_reg <= ts_sh_reg << 4;
        if (byte_idx_reg >= SEQ_FIRST && byte_idx_reg < CR_IDX)
          seq_sh_reg <= seq_sh_reg << 4;
      end
    end
  end

  assign tx_data     = tx_data_reg;
  assign new_tx_data = new_tx_data_reg;
  assign overrun     = overrun_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_multi_channel_timestamp_printer.sv
// Scoreboard bench: stimulus queues the expected line bytes, a monitor pops and
// compares them on every tx strobe and checks strobe spacing.
module tb_multi_channel_timestamp_printer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sig_in = '0;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = '0;
  logic       new_rx_data = 1'b0;
  logic       overrun;
  logic [7:0] drop_count;

  int          tests = 0;
  int          fails = 0;
  int          strobe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] tb_cnt;
  logic [15:0] exp_seq = '0;
  logic        prev_strobe = 1'b0;
  logic [7:0]  exp_b;
  string       line_s = "";

  multi_channel_timestamp_printer #(
    .NCH(4), .COUNT_W(32), .SEQ_W(16), .DEPTH(8), .EDGE_MODE(0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Reference for the free-running timestamp counter.
  always @(posedge clk) tb_cnt <= rst ? 32'd0 : tb_cnt + 32'd1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
        line_s = "";
      end else begin
        if (new_tx_data) begin
          strobe_cnt++;
          tests++;
          if (prev_strobe) begin
            fails++;
            $display("FAIL gap: strobe on consecutive cycles, got 1 need 0");
          end
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL byte: got unexpected 0x%02h, need no strobe", tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
              fails++;
              $display("FAIL byte: got 0x%02h, need 0x%02h", tx_data, exp_b);
            end
          end
          if (tx_data >= 8'h20) line_s = $sformatf("%s%c", line_s, tx_data);
          if (tx_data == 8'h0A) begin
            $display("[TB] line printed: %s", line_s);
            line_s = "";
          end
        end
        prev_strobe = new_tx_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic expect_string(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic expect_line(input logic [3:0] id, input logic [31:0] ts);
    exp_seq = exp_seq + 16'd1;
    exp_q.push_back(8'h43);
    exp_q.push_back(hexc(id));
    exp_q.push_back(8'h3A);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(ts[i*4 +: 4]));
    exp_q.push_back(8'h2C);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexc(exp_seq[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Pin rise at tb_cnt=c is captured with timestamp c+2 (3-stage input path).
  task automatic pulse(input logic [3:0] mask);
    sig_in = mask;
    tick(6);
    sig_in = '0;
    tick(4);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    tick(1);
    new_rx_data = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d bytes unsent after %0d cycles, need 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    tick(60);
  endtask

  task automatic wait_strobes(input string name, input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    tests++;
    if (strobe_cnt < target) begin
      fails++;
      $display("FAIL %s: got %0d strobes, need %0d", name, strobe_cnt, target);
    end
  endtask

  initial begin
    logic [31:0] ts;
    logic [3:0]  m;
    int          base;
    int          snap;

    tick(3);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_new_tx_data", 32'(new_tx_data), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    exp_seq = '0;

    // ch2 rising edge captured at counter 0x1000
    while (tb_cnt != 32'h0000_0ffe) tick(1);
    expect_string("C2:00001000,0001");
    pulse(4'b0100);
    wait_drain("ch2_line", 200);

    // ch0 and ch3 together: same timestamp, ch0 printed first
    ts = tb_cnt + 32'd2;
    expect_line(4'd0, ts);
    expect_line(4'd3, ts);
    pulse(4'b1001);
    wait_drain("simultaneous", 300);

    // tx_busy held for 500 cycles mid-line
    ts = tb_cnt + 32'd2;
    expect_line(4'd1, ts);
    base = strobe_cnt;
    pulse(4'b0010);
    wait_strobes("busy_midline", base + 5, 200);
    tx_busy = 1'b1;
    tick(1);
    snap = strobe_cnt;
    tick(499);
    check("busy_hold_strobes", 32'(strobe_cnt), 32'(snap));
    tx_busy = 1'b0;
    wait_drain("busy_resume", 300);

    // One line parked in the printer, 9 more edges: 8 fit the FIFO, 1 lost
    tx_busy = 1'b1;
    ts = tb_cnt + 32'd2;
    expect_line(4'd0, ts);
    pulse(4'b0001);
    tick(5);
    for (int k = 0; k < 9; k++) begin
      m = 4'b0001 << ((k + 1) % 4);
      ts = tb_cnt + 32'd2;
      if (k < 8) expect_line(4'((k + 1) % 4), ts);
      pulse(m);
    end
    tick(5);
    check("overflow_overrun", 32'(overrun), 32'd1);
    check("overflow_drop_count", 32'(drop_count), 32'd1);
    tx_busy = 1'b0;
    wait_drain("overflow_lines", 2000);
    send_cmd(8'h63);
    check("clear_overrun", 32'(overrun), 32'd0);
    check("clear_drop_count", 32'(drop_count), 32'd0);

    // Disabled: edge ignored; then enable and inject a software event
    send_cmd(8'h64);
    base = strobe_cnt;
    pulse(4'b0010);
    tick(60);
    check("disabled_no_line", 32'(strobe_cnt), 32'(base));
    send_cmd(8'h65);
    ts = tb_cnt;
    expect_line(4'hF, ts);
    send_cmd(8'h68);
    wait_drain("host_event", 200);

    // Reset in the middle of a line with a second line still queued
    ts = tb_cnt + 32'd2;
    expect_line(4'd0, ts);
    expect_line(4'd2, ts);
    base = strobe_cnt;
    pulse(4'b0101);
    wait_strobes("reset_midline", base + 4, 200);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check("rst_strobe_low", 32'(new_tx_data), 32'd0);
    tick(1);
    rst = 1'b0;
    exp_seq = '0;
    snap = strobe_cnt;
    tick(80);
    check("rst_fifo_flushed", 32'(strobe_cnt), 32'(snap));
    ts = tb_cnt + 32'd2;
    expect_line(4'd3, ts);
    pulse(4'b1000);
    wait_drain("post_reset_line", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
